// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   PC_W          - PC / instruction width (16)
//   NOP_ENC       - bubble encoding presented when no valid instruction exists
//   HALT_ENC      - encoding that stops fetch
//   fetch_state_t - fetch FSM states (2-bit encoding)
//   pc_inc()      - next sequential PC, wraps modulo 2^16
package fetch_pkg;

   localparam int PC_W = 16;

   localparam logic [PC_W-1:0] NOP_ENC  = 16'h0800;
   localparam logic [PC_W-1:0] HALT_ENC = 16'h0000;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + 16'd2;
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: holds one fetched instruction and its PC while the
// decode stage is stalled.
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture instr_in / pc_in
//   clear     - drop the buffered instruction (back to NOP)
//   instr_in  - instruction to capture
//   pc_in     - PC of that instruction
//   instr     - buffered instruction
//   pc        - buffered PC
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [PC_W-1:0] instr_in,
   input  logic [PC_W-1:0] pc_in,
   output logic [PC_W-1:0] instr,
   output logic [PC_W-1:0] pc
);

   // Buffer register: clear wins over load so a redirect always drops it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         instr <= NOP_ENC;
         pc    <= 16'h0000;
      end else if (load) begin
         instr <= instr_in;
         pc    <= pc_in;
      end else begin
         instr <= instr;
         pc    <= pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit 5-stage pipeline.
// Owns the PC, issues reads to a variable-latency instruction memory and
// presents instruction / PC / PC+2 to the IF/ID register each cycle.
// Optional macro FETCH_ALIGN_CHK_EN adds misaligned-PC detection
// (misalign_err output); without it pc[0] is passed through unchecked.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   stall              - IF/ID hold request; presented instruction not accepted
//   redirect_valid/pc  - taken branch/jump and its target
//   imem_rd/addr       - memory read request and address
//   imem_rdata/done    - memory read data and completion
//   instr_out, pc_out, pc_plus_two_out, instr_valid - to IF/ID
//   halted             - fetch stopped on HALT
//   misalign_err       - (macro only) sticky misaligned-PC flag
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] NOP_INSTR  = NOP_ENC,
   parameter logic [15:0] HALT_INSTR = HALT_ENC
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            imem_rd,
   output logic [PC_W-1:0] imem_addr,
   input  logic [PC_W-1:0] imem_rdata,
   input  logic            imem_done,
   output logic [PC_W-1:0] instr_out,
   output logic [PC_W-1:0] pc_out,
   output logic [PC_W-1:0] pc_plus_two_out,
   output logic            instr_valid,
   output logic            halted
`ifdef FETCH_ALIGN_CHK_EN
   ,
   output logic            misalign_err
`endif
);

   fetch_state_t    state_r, state_nxt_s;
   logic [PC_W-1:0] pc_r, pc_nxt_s;
   logic [PC_W-1:0] pend_r, pend_nxt_s;
   logic            hold_load_s, hold_clear_s;
   logic [PC_W-1:0] hold_instr_s, hold_pc_s;
   logic            misaligned_s;

`ifdef FETCH_ALIGN_CHK_EN
   logic misalign_r;

   assign misaligned_s = pc_r[0];
   assign misalign_err = misalign_r;

   // Sticky misalignment flag, cleared only by reset or a redirect.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         misalign_r <= 1'b0;
      end else if ((state_r == FETCH) && pc_r[0]) begin
         misalign_r <= 1'b1;
      end else begin
         misalign_r <= misalign_r;
      end
   end
`else
   assign misaligned_s = 1'b0;
`endif

   fetch_hold_buf u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load_s),
      .clear    (hold_clear_s),
      .instr_in (imem_rdata),
      .pc_in    (pc_r),
      .instr    (hold_instr_s),
      .pc       (hold_pc_s)
   );

   // State, PC and pending redirect target registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= FETCH;
         pc_r    <= RESET_PC;
         pend_r  <= RESET_PC;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         pend_r  <= pend_nxt_s;
      end
   end

   // Next-state logic and IF/ID presentation; redirect has top priority.
   always_comb begin
      state_nxt_s  = state_r;
      pc_nxt_s     = pc_r;
      pend_nxt_s   = pend_r;
      hold_load_s  = 1'b0;
      hold_clear_s = 1'b0;
      imem_rd      = 1'b0;
      imem_addr    = pc_r;
      instr_out    = NOP_INSTR;
      instr_valid  = 1'b0;
      halted       = 1'b0;
      pc_out       = pc_r;

      case (state_r)
         FETCH: begin
            imem_rd = !misaligned_s;
            if (redirect_valid) begin
               // An outstanding read must drain before the new address is used.
               if (!misaligned_s && !imem_done) begin
                  state_nxt_s = SQUASH;
                  pend_nxt_s  = redirect_pc;
               end else begin
                  pc_nxt_s     = redirect_pc;
                  hold_clear_s = 1'b1;
               end
            end else if (!misaligned_s && imem_done) begin
               instr_valid = 1'b1;
               instr_out   = imem_rdata;
               if (stall) begin
                  hold_load_s = 1'b1;
                  state_nxt_s = HOLD;
               end else if (imem_rdata == HALT_INSTR) begin
                  state_nxt_s = HALTED;
               end else begin
                  pc_nxt_s = pc_inc(pc_r);
               end
            end else begin
               state_nxt_s = FETCH;
            end
         end
         HOLD: begin
            pc_out = hold_pc_s;
            if (redirect_valid) begin
               hold_clear_s = 1'b1;
               pc_nxt_s     = redirect_pc;
               state_nxt_s  = FETCH;
            end else begin
               instr_valid = 1'b1;
               instr_out   = hold_instr_s;
               if (stall) begin
                  state_nxt_s = HOLD;
               end else if (hold_instr_s == HALT_INSTR) begin
                  state_nxt_s = HALTED;
               end else begin
                  pc_nxt_s    = pc_inc(pc_r);
                  state_nxt_s = FETCH;
               end
            end
         end
         SQUASH: begin
            // Old address stays on the bus until the abandoned read completes.
            imem_rd = 1'b1;
            if (redirect_valid) begin
               pend_nxt_s = redirect_pc;
            end else begin
               pend_nxt_s = pend_r;
            end
            if (imem_done) begin
               pc_nxt_s    = redirect_valid ? redirect_pc : pend_r;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = SQUASH;
            end
         end
         HALTED: begin
            halted = 1'b1;
            if (redirect_valid) begin
               pc_nxt_s    = redirect_pc;
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = HALTED;
            end
         end
         default: begin
            state_nxt_s = FETCH;
         end
      endcase

      // Nothing is requested or presented while reset is asserted.
      if (rst) begin
         imem_rd     = 1'b0;
         instr_valid = 1'b0;
         instr_out   = NOP_INSTR;
      end else begin
         imem_rd     = imem_rd;
      end
   end

   assign pc_plus_two_out = pc_inc(pc_out);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Memory is either a zero-latency
// model (done = rd, rdata = 16'h4000 + addr) or driven by hand step by step.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_done;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic [15:0] pc_plus_two_out;
   logic        instr_valid;
   logic        halted;

   logic        zl = 1'b1;
   logic        done_drv = 1'b0;
   logic [15:0] rdata_drv = 16'h0000;

   int checks = 0;
   int errors = 0;

   assign imem_done  = zl ? imem_rd : done_drv;
   assign imem_rdata = zl ? (16'h4000 + imem_addr) : rdata_drv;

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_rd         (imem_rd),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_done       (imem_done),
      .instr_out       (instr_out),
      .pc_out          (pc_out),
      .pc_plus_two_out (pc_plus_two_out),
      .instr_valid     (instr_valid),
      .halted          (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with zero-latency memory
      tick();
      chk("rst_rd", {15'd0, imem_rd}, 16'h0000);
      chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
      chk("rst_instr", instr_out, 16'h0800);
      chk("rst_halted", {15'd0, halted}, 16'h0000);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_pc2", pc_plus_two_out, 16'h0002);
      rst = 1'b0;
      #1;
      chk("zl_valid0", {15'd0, instr_valid}, 16'h0001);
      chk("zl_pc0", pc_out, 16'h0000);
      chk("zl_instr0", instr_out, 16'h4000);
      tick();
      chk("zl_pc1", pc_out, 16'h0002);
      chk("zl_instr1", instr_out, 16'h4002);
      tick();
      chk("zl_pc2", pc_out, 16'h0004);
      chk("zl_valid2", {15'd0, instr_valid}, 16'h0001);

      // 3-cycle latency read of 0x0000
      zl = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("lat_addr_c1", imem_addr, 16'h0000);
      chk("lat_valid_c1", {15'd0, instr_valid}, 16'h0000);
      tick();
      chk("lat_addr_c2", imem_addr, 16'h0000);
      chk("lat_valid_c2", {15'd0, instr_valid}, 16'h0000);
      tick();
      done_drv = 1'b1;
      rdata_drv = 16'h1234;
      #1;
      chk("lat_addr_c3", imem_addr, 16'h0000);
      chk("lat_valid_c3", {15'd0, instr_valid}, 16'h0001);
      chk("lat_instr_c3", instr_out, 16'h1234);
      tick();
      done_drv = 1'b0;
      #1;
      chk("lat_next_addr", imem_addr, 16'h0002);
      chk("lat_valid_after", {15'd0, instr_valid}, 16'h0000);

      // Redirect coincident with done goes straight to the target (0x0010)
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      done_drv = 1'b1;
      rdata_drv = 16'h7777;
      #1;
      chk("redir_done_valid", {15'd0, instr_valid}, 16'h0000);
      tick();
      redirect_valid = 1'b0;
      done_drv = 1'b0;
      #1;
      chk("redir_done_addr", imem_addr, 16'h0010);
      chk("redir_done_rd", {15'd0, imem_rd}, 16'h0001);

      // Stall held 2 cycles as done arrives for 0x0010
      stall = 1'b1;
      done_drv = 1'b1;
      rdata_drv = 16'hABCD;
      #1;
      chk("stall_instr_c1", instr_out, 16'hABCD);
      tick();
      done_drv = 1'b0;
      rdata_drv = 16'h0000;
      #1;
      chk("stall_rd_c2", {15'd0, imem_rd}, 16'h0000);
      chk("stall_instr_c2", instr_out, 16'hABCD);
      chk("stall_valid_c2", {15'd0, instr_valid}, 16'h0001);
      chk("stall_pc_c2", pc_out, 16'h0010);
      tick();
      stall = 1'b0;
      #1;
      chk("stall_accept_instr", instr_out, 16'hABCD);
      chk("stall_accept_valid", {15'd0, instr_valid}, 16'h0001);
      tick();
      chk("stall_next_addr", imem_addr, 16'h0012);
      chk("stall_next_rd", {15'd0, imem_rd}, 16'h0001);

      // Redirect to 0x0100 while a read of 0x0020 is outstanding
      redirect_valid = 1'b1;
      redirect_pc = 16'h0020;
      done_drv = 1'b1;
      tick();
      redirect_valid = 1'b0;
      done_drv = 1'b0;
      #1;
      chk("sq_addr_c1", imem_addr, 16'h0020);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      #1;
      chk("sq_valid_redir", {15'd0, instr_valid}, 16'h0000);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("sq_rd_hold", {15'd0, imem_rd}, 16'h0001);
      chk("sq_addr_hold", imem_addr, 16'h0020);
      tick();
      done_drv = 1'b1;
      rdata_drv = 16'hDEAD;
      #1;
      chk("sq_discard_valid", {15'd0, instr_valid}, 16'h0000);
      chk("sq_discard_instr", instr_out, 16'h0800);
      tick();
      done_drv = 1'b0;
      #1;
      chk("sq_next_addr", imem_addr, 16'h0100);

      // HALT fetched at 0x0030
      redirect_valid = 1'b1;
      redirect_pc = 16'h0030;
      done_drv = 1'b1;
      tick();
      redirect_valid = 1'b0;
      rdata_drv = 16'h0000;
      #1;
      chk("halt_addr", imem_addr, 16'h0030);
      chk("halt_valid", {15'd0, instr_valid}, 16'h0001);
      chk("halt_instr", instr_out, 16'h0000);
      tick();
      done_drv = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("halt_flag", {15'd0, halted}, 16'h0001);
         chk("halt_rd", {15'd0, imem_rd}, 16'h0000);
         chk("halt_pc", pc_out, 16'h0030);
         tick();
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("resume_halted", {15'd0, halted}, 16'h0000);
      chk("resume_rd", {15'd0, imem_rd}, 16'h0001);
      chk("resume_addr", imem_addr, 16'h0040);

      // PC wrap at 0xFFFE
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFE;
      done_drv = 1'b1;
      rdata_drv = 16'h1111;
      tick();
      redirect_valid = 1'b0;
      done_drv = 1'b0;
      #1;
      chk("wrap_pc", pc_out, 16'hFFFE);
      chk("wrap_pc2", pc_plus_two_out, 16'h0000);
      tick();

      // Reset mid-read; the late done lands in the reset cycle
      rst = 1'b1;
      done_drv = 1'b1;
      rdata_drv = 16'h5555;
      #1;
      chk("rstmid_rd", {15'd0, imem_rd}, 16'h0000);
      chk("rstmid_valid", {15'd0, instr_valid}, 16'h0000);
      tick();
      rst = 1'b0;
      done_drv = 1'b0;
      #1;
      chk("rstmid_pc", pc_out, 16'h0000);
      chk("rstmid_valid_after", {15'd0, instr_valid}, 16'h0000);
      chk("rstmid_instr_after", instr_out, 16'h0800);
      chk("rstmid_rd_after", {15'd0, imem_rd}, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
